// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, access size codes,
// captured request layout and the alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Size code 2'b11 is handled as a word everywhere.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between a core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_byte_array.sv
// Big-endian byte store: lane 0 is the byte at addr and maps to the most significant
// byte of the access; lane addresses wrap modulo DEPTH_BYTES.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0]                mem [DEPTH_BYTES];
    logic [3:0][ADDR_W-1:0]    lane_addr;
    logic [3:0][7:0]           rd_b;
    logic [3:0][7:0]           wr_b;
    logic [3:0]                lane_en;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane_addr[i] = addr + ADDR_W'(i);
        assign rd_b[i]      = mem[lane_addr[i]];
    end

    // Store data is right-aligned, so the last enabled lane takes wdata[7:0].
    always_comb begin
        lane_en = 4'b0000;
        wr_b    = '0;
        rdata   = '0;
        case (size)
            SZ_BYTE: begin
                lane_en = 4'b0001;
                wr_b[0] = wdata[7:0];
                rdata   = {24'b0, rd_b[0]};
            end
            SZ_HALF: begin
                lane_en = 4'b0011;
                wr_b[0] = wdata[15:8];
                wr_b[1] = wdata[7:0];
                rdata   = {16'b0, rd_b[0], rd_b[1]};
            end
            default: begin
                lane_en = 4'b1111;
                wr_b[0] = wdata[31:24];
                wr_b[1] = wdata[23:16];
                wr_b[2] = wdata[15:8];
                wr_b[3] = wdata[7:0];
                rdata   = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && lane_en[i]) mem[lane_addr[i]] <= wr_b[i];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, registered response.
// Optional alignment faulting is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept, access, bad, we;
    dmem_req_t        live, req_q, acc;
    logic [31:0]      arr_rdata, rdata_q;
    logic             unused_addr_hi;

    assign live = '{write: bus.req_write, size: bus.req_size,
                    addr: bus.req_addr, wdata: bus.req_wdata};

    // With zero wait states the access happens on the accept edge, straight from the bus.
    assign acc            = (state == IDLE) ? live : req_q;
    assign unused_addr_hi = ^acc.addr[31:ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad = misaligned(acc.size, acc.addr[1:0]);
`else
    assign bad = 1'b0;
`endif

    assign we = access && acc.write && !bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access   = 1'b1;
                        state_nx = RESP;
                    end else begin
                        cnt_nx   = CNT_W'(WAIT_CYCLES);
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    access   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) req_q <= live;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (access) begin
            rdata_q <= (acc.write || bad) ? 32'h0 : arr_rdata;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (access) err_q <= bad;
        else if (accept) err_q <= 1'b0;
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .size  (acc.size),
        .addr  (acc.addr[ADDR_W-1:0]),
        .wdata (acc.wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses, a negedge
// monitor pops and checks data, error flag and accept-to-valid latency.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WAITC = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   lat_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_BYTES (32),
        .ADDR_W      (5),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: latency on each rising rsp_valid, payload on each completed handshake.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && !prev_v) begin
                if (lat_q.size() == 0) begin
                    n_run++; n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid rose with no accepted request");
                end else begin
                    check("latency", 32'(cyc - lat_q.pop_front()), 32'(WAITC));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
                check({e.name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
            end
            prev_v = bus.rsp_valid;
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic wait_idle(input string name);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) begin
            n_run++; n_fail++;
            $display("FAIL %s: req_ready timeout", name);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input string name, input bit expect_rsp);
        exp_t e;
        wait_idle(name);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (expect_rsp) begin
            e.rdata = exp_rd; e.err = exp_err; e.name = name;
            sb_q.push_back(e);
            lat_q.push_back(cyc);
        end
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;

        // Big-endian lane mapping
        issue(1, SZ_WORD, 32'd4, 32'hDEADBEEF, 32'h0, 0, "st_w4", 1);
        issue(0, SZ_WORD, 32'd4, 32'h0, 32'hDEADBEEF, 0, "ld_w4", 1);
        issue(0, SZ_BYTE, 32'd4, 32'h0, 32'h000000DE, 0, "ld_b4", 1);
        issue(0, SZ_BYTE, 32'd7, 32'h0, 32'h000000EF, 0, "ld_b7", 1);
        issue(0, SZ_HALF, 32'd6, 32'h0, 32'h0000BEEF, 0, "ld_h6", 1);

        // Wrap-around past the top of the array
        issue(1, SZ_WORD, 32'd0,  32'h0,    32'h0, 0, "st_w0",  1);
        issue(1, SZ_HALF, 32'd30, 32'h1234, 32'h0, 0, "st_h30", 1);
        issue(0, SZ_WORD, 32'd30, 32'h0, ALIGN ? 32'h0 : 32'h12340000, ALIGN, "ld_w30", 1);

        // Backpressure: response held, concurrent request ignored
        wait_idle("stall_pre");
        bus.rsp_ready = 1'b0;
        issue(0, SZ_WORD, 32'd4, 32'h0, 32'hDEADBEEF, 0, "ld_w4_stall", 1);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",     {31'b0, bus.rsp_valid}, 32'd1);
            check("stall_rdata",     bus.rsp_rdata, 32'hDEADBEEF);
            check("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_size  = SZ_WORD;
            bus.req_addr  = 32'd4;
            bus.req_wdata = 32'h11111111;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid",     {31'b0, bus.rsp_valid}, 32'd0);
        check("release_req_ready", {31'b0, bus.req_ready}, 32'd1);
        issue(0, SZ_WORD, 32'd4, 32'h0, 32'hDEADBEEF, 0, "ld_w4_after_stall", 1);

        // Reset while in WAIT discards the pending store
        issue(1, SZ_BYTE, 32'd8, 32'h00, 32'h0, 0, "st_b8", 1);
        issue(1, SZ_BYTE, 32'd8, 32'hFF, 32'h0, 0, "st_b8_killed", 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        issue(0, SZ_BYTE, 32'd8, 32'h0, 32'h0, 0, "ld_b8", 1);

        // Misaligned accesses: faulted with the check built in, wrapped lanes otherwise
        issue(0, SZ_WORD, 32'd2, 32'h0, ALIGN ? 32'h0 : 32'h0000DEAD, ALIGN, "ld_w2", 1);
        issue(1, SZ_WORD, 32'd1, 32'hFFFFFFFF, 32'h0, ALIGN, "st_w1", 1);
        issue(0, SZ_WORD, 32'd0, 32'h0, ALIGN ? 32'h0 : 32'h00FFFFFF, 0, "ld_w0", 1);

        wait_idle("drain");
        repeat (2) begin @(posedge clk); #1; end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
